work_rest_sched: RTL and testbench

WORK_REST_SCHED -- requirements
Module: work_rest_sched

---
 rtl/sched_pkg.sv | 13 +
 rtl/sched_down_counter.sv | 27 ++
 rtl/work_rest_sched.sv | 151 +++++++++++++++
 tb/tb_work_rest_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared state encodings for the work/rest burst scheduler.
// Encoding 3 is never produced and is decoded back to SLEEPING.
package sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SLEEPING = 2'd0,
        WORKING  = 2'd1,
        RESTING  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down counter with a zero flag; decrement stops at zero.
module sched_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/work_rest_sched.sv
// Accepts a job (base payload + beat count), emits base+k beats with
// valid/ready flow control, then idles REST_CYCLES cycles before the next job.
module work_rest_sched
    import sched_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int BURST_MAX   = 16,
    parameter  int REST_CYCLES = 4,
    localparam int LEN_W       = $clog2(BURST_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        state_o
);

    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(BURST_MAX);
    localparam int               REST_W    = (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;
    // Timer counts REST_CYCLES-1 down to 0, so RESTING spans exactly REST_CYCLES cycles.
    localparam logic [REST_W-1:0] REST_LOAD = REST_W'(REST_CYCLES - 1);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;
    logic [LEN_W-1:0]  r_beat;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;

    logic [LEN_W-1:0]  w_len_clamp;
    logic [LEN_W-1:0]  w_beat_nxt;
    logic              w_hs;
    logic              w_accept;
    logic              w_rest_load;
    logic              w_rest_dec;
    logic              w_rest_zero;

    assign w_len_clamp = clamp_len(in_len);
    assign w_beat_nxt  = r_beat + LEN_W'(1);
    assign w_hs        = r_out_valid && out_ready;
    assign w_accept    = (r_state == SLEEPING) && in_valid;
    assign w_rest_load = (w_state_nxt == RESTING) && (r_state != RESTING);
    assign w_rest_dec  = (r_state == RESTING);

    sched_down_counter #(
        .CNT_W (REST_W)
    ) u_rest_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_rest_load),
        .i_load_val (REST_LOAD),
        .i_dec      (w_rest_dec),
        .o_zero     (w_rest_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SLEEPING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLEEPING: begin
                if (in_valid) begin
                    w_state_nxt = (w_len_clamp == '0) ? RESTING : WORKING;
                end
            end
            WORKING: begin
                if (abort) begin
                    w_state_nxt = SLEEPING;
                end else if (w_hs && r_out_last) begin
                    w_state_nxt = RESTING;
                end
            end
            RESTING: begin
                if (w_rest_zero) begin
                    w_state_nxt = SLEEPING;
                end
            end
            default: w_state_nxt = SLEEPING;
        endcase
    end

    always_comb begin
        in_ready = (r_state == SLEEPING);
        state_o  = r_state;
    end

    // Beat counter and registered output stage; outputs hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat      <= '0;
            r_len       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                SLEEPING: begin
                    if (w_accept && (w_len_clamp != '0)) begin
                        r_beat      <= '0;
                        r_len       <= w_len_clamp;
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (w_len_clamp == LEN_W'(1));
                    end
                end
                WORKING: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (w_hs) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_beat     <= w_beat_nxt;
                            r_out_data <= r_out_data + DATA_W'(1);
                            r_out_last <= (w_beat_nxt == (r_len - LEN_W'(1)));
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_work_rest_sched.sv
// Scenario bench for work_rest_sched against a transaction-level beat model.
module tb_work_rest_sched;

    localparam int DW = 8;
    localparam int BM = 16;
    localparam int RC = 4;
    localparam int LW = $clog2(BM + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [LW-1:0] in_len;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    bit            col_timeout;

    always #5 clk = ~clk;

    work_rest_sched #(
        .DATA_W      (DW),
        .BURST_MAX   (BM),
        .REST_CYCLES (RC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .state_o   (state_o)
    );

    // Reference: a job of length l yields min(l, BM) beats, beat k = base + k mod 2^DW.
    function automatic int model_beats(input int l);
        return (l > BM) ? BM : l;
    endfunction

    function automatic logic [DW-1:0] model_data(input logic [DW-1:0] base, input int k);
        return DW'(int'(base) + k);
    endfunction

    // Present a job for one cycle; returns at the following falling edge.
    task automatic send_job(input logic [DW-1:0] d, input logic [LW-1:0] l);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_len   = LW'($urandom);
    endtask

    // Record every handshaken beat until the burst ends or valid drops.
    task automatic collect(input bit rand_ready);
        got_data.delete();
        got_last.delete();
        col_timeout = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!out_valid) begin
                col_timeout = 1'b0;
                break;
            end
            if (out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (out_last) begin
                    @(negedge clk);
                    col_timeout = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic measure_rest(output int n, output bit valid_seen);
        n = 0;
        valid_seen = 1'b0;
        while ((state_o == 2'd2) && (n < 50)) begin
            if (out_valid) valid_seen = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL reset_state got %0d want 0", state_o);
        end
        checks++;
        if ({out_valid, out_last, out_data} !== '0) begin
            errors++; $display("FAIL reset_outputs got v=%b l=%b d=%h want all 0", out_valid, out_last, out_data);
        end
    endtask

    task automatic test_basic();
        int n;
        bit vs;
        out_ready = 1'b1;
        send_job(8'h10, LW'(3));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== model_data(8'h10, k) || out_last !== (k == 2)) begin
                errors++;
                $display("FAIL basic_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, out_valid, out_data, out_last, model_data(8'h10, k), (k == 2));
            end
            @(negedge clk);
        end
        measure_rest(n, vs);
        checks++;
        if (n !== RC || vs) begin
            errors++; $display("FAIL basic_rest got %0d cycles valid_seen=%b want %0d cycles no valid", n, vs, RC);
        end
        checks++;
        if (in_ready !== 1'b1 || state_o !== 2'd0) begin
            errors++; $display("FAIL basic_sleep got ready=%b state=%0d want ready=1 state=0", in_ready, state_o);
        end
    endtask

    task automatic test_wrap();
        int n;
        bit vs;
        send_job(8'hFE, LW'(4));
        collect(1'b0);
        checks++;
        if (col_timeout || got_data.size() != 4) begin
            errors++; $display("FAIL wrap_count got %0d timeout=%b want 4", got_data.size(), col_timeout);
        end
        for (int k = 0; k < got_data.size() && k < 4; k++) begin
            checks++;
            if (got_data[k] !== model_data(8'hFE, k) || got_last[k] !== (k == 3)) begin
                errors++;
                $display("FAIL wrap_beat%0d got d=%h l=%b want d=%h l=%b", k, got_data[k], got_last[k], model_data(8'hFE, k), (k == 3));
            end
        end
        measure_rest(n, vs);
    endtask

    task automatic test_backpressure();
        int n;
        bit vs;
        out_ready = 1'b1;
        send_job(8'h20, LW'(4));
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h20) begin
            errors++; $display("FAIL bp_beat0 got v=%b d=%h want v=1 d=20", out_valid, out_data);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h21 || out_last !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=21 l=0", i, out_valid, out_data, out_last);
            end
            @(negedge clk);
        end
        collect(1'b0);
        checks++;
        if (col_timeout || got_data.size() != 3) begin
            errors++; $display("FAIL bp_count got %0d timeout=%b want 3", got_data.size(), col_timeout);
        end
        for (int k = 0; k < got_data.size() && k < 3; k++) begin
            checks++;
            if (got_data[k] !== model_data(8'h20, k + 1) || got_last[k] !== (k == 2)) begin
                errors++;
                $display("FAIL bp_beat%0d got d=%h l=%b want d=%h l=%b", k + 1, got_data[k], got_last[k], model_data(8'h20, k + 1), (k == 2));
            end
        end
        measure_rest(n, vs);
        checks++;
        if (n !== RC) begin
            errors++; $display("FAIL bp_rest got %0d want %0d", n, RC);
        end
    endtask

    task automatic test_clamp();
        int n;
        bit vs;
        logic [DW-1:0] base;
        base = DW'($urandom);
        send_job(base, LW'(20));
        collect(1'b0);
        checks++;
        if (col_timeout || got_data.size() != model_beats(20)) begin
            errors++; $display("FAIL clamp_count got %0d want %0d", got_data.size(), model_beats(20));
        end
        for (int k = 0; k < got_data.size(); k++) begin
            checks++;
            if (got_data[k] !== model_data(base, k) || got_last[k] !== (k == BM - 1)) begin
                errors++;
                $display("FAIL clamp_beat%0d got d=%h l=%b want d=%h l=%b", k, got_data[k], got_last[k], model_data(base, k), (k == BM - 1));
            end
        end
        measure_rest(n, vs);
        send_job(8'h33, LW'(0));
        measure_rest(n, vs);
        checks++;
        if (n !== RC || vs) begin
            errors++; $display("FAIL zero_len_rest got %0d cycles valid_seen=%b want %0d no valid", n, vs, RC);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL zero_len_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        send_job(8'h40, LW'(10));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h42) begin
            errors++; $display("FAIL abort_beat2 got v=%b d=%h want v=1 d=42", out_valid, out_data);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (state_o !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_stop got state=%0d v=%b ready=%b want state=0 v=0 ready=1", state_o, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (state_o !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_no_rest got state=%0d v=%b want state=0 v=0", state_o, out_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (state_o !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle got state=%0d ready=%b want state=0 ready=1", state_o, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_job(8'h55, LW'(8));
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || state_o !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async got v=%b d=%h l=%b state=%0d ready=%b want all idle", out_valid, out_data, out_last, state_o, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || state_o !== 2'd0) begin
            errors++; $display("FAIL rst_mid_quiet got v=%b state=%0d want v=0 state=0", out_valid, state_o);
        end
        send_job(8'h60, LW'(2));
        collect(1'b0);
        checks++;
        if (col_timeout || got_data.size() != 2 || got_data[0] !== 8'h60 || got_data[1] !== 8'h61 || got_last[1] !== 1'b1) begin
            errors++; $display("FAIL rst_mid_restart got %0d beats first=%h want 2 beats 60,61", got_data.size(),
                               (got_data.size() > 0) ? got_data[0] : 8'hxx);
        end
    endtask

    task automatic test_random();
        int n;
        int exp_n;
        int l;
        bit vs;
        logic [DW-1:0] base;
        for (int j = 0; j < 25; j++) begin
            base = DW'($urandom);
            l = $urandom_range(0, 20);
            exp_n = model_beats(l);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL rand%0d_ready got %b want 1", j, in_ready);
            end
            send_job(base, LW'(l));
            if (exp_n > 0) begin
                collect(1'b1);
                checks++;
                if (col_timeout || got_data.size() != exp_n) begin
                    errors++; $display("FAIL rand%0d_count got %0d timeout=%b want %0d", j, got_data.size(), col_timeout, exp_n);
                end
                for (int k = 0; k < got_data.size(); k++) begin
                    checks++;
                    if (got_data[k] !== model_data(base, k) || got_last[k] !== (k == exp_n - 1)) begin
                        errors++;
                        $display("FAIL rand%0d_beat%0d got d=%h l=%b want d=%h l=%b", j, k, got_data[k], got_last[k], model_data(base, k), (k == exp_n - 1));
                    end
                end
            end
            measure_rest(n, vs);
            checks++;
            if (n !== RC || vs) begin
                errors++; $display("FAIL rand%0d_rest got %0d valid_seen=%b want %0d", j, n, vs, RC);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_clamp();
        test_abort();
        test_reset_mid();
        out_ready = 1'b1;
        begin
            int n;
            bit vs;
            measure_rest(n, vs);
        end
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
